// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port with per-byte enables, one read port
// with a 1- or 2-stage valid-tagged read pipeline and defined same-address collision results.
module bram_sdp #(
  parameter  int RAM_WIDTH      = 32,
  parameter  int RAM_ADDR_BITS  = 8,
  parameter  int BYTE_WIDTH     = 8,
  parameter  int READ_LATENCY   = 1,
  parameter  int COLLISION_MODE = 0,
  localparam int NUM_BYTES      = RAM_WIDTH / BYTE_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] write_address,
  input  logic [RAM_WIDTH-1:0]     write_data,
  input  logic [NUM_BYTES-1:0]     write_byte_enable,
  input  logic                     read_enable,
  input  logic [RAM_ADDR_BITS-1:0] read_address,
  output logic [RAM_WIDTH-1:0]     read_data,
  output logic                     read_valid,
  output logic                     read_collision
);

  localparam int DEPTH = 2 ** RAM_ADDR_BITS;

  if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("bram_sdp: RAM_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_sdp: READ_LATENCY must be 1 or 2");
  end

  logic [RAM_WIDTH-1:0] mem [DEPTH];

  logic [RAM_WIDTH-1:0] old_word;
  logic [RAM_WIDTH-1:0] merged_word;
  logic                 collision;

  always_comb begin
    old_word    = mem[read_address];
    merged_word = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (write_byte_enable[i]) begin
        merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    collision = write_enable && read_enable && (write_address == read_address) &&
                (|write_byte_enable);
  end

  // Array is intentionally not reset; writes are only blocked while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && write_enable) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (write_byte_enable[i]) begin
          mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [RAM_WIDTH-1:0] s1_data;
  logic                 s1_valid;
  logic                 s1_collision;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_data      <= '0;
      s1_valid     <= 1'b0;
      s1_collision <= 1'b0;
    end else begin
      s1_valid     <= read_enable;
      s1_collision <= read_enable && collision;
      if (read_enable) begin
        s1_data <= (COLLISION_MODE == 1 && collision) ? merged_word : old_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [RAM_WIDTH-1:0] s2_data;
    logic                 s2_valid;
    logic                 s2_collision;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s2_data      <= '0;
        s2_valid     <= 1'b0;
        s2_collision <= 1'b0;
      end else begin
        s2_valid     <= s1_valid;
        s2_collision <= s1_collision;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign read_data      = s2_data;
    assign read_valid     = s2_valid;
    assign read_collision = s2_collision;
  end else begin : g_lat1
    assign read_data      = s1_data;
    assign read_valid     = s1_valid;
    assign read_collision = s1_collision;
  end

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: two instances (latency 1 / mode 0 and latency 2 / mode 1) share stimulus;
// a word-level reference memory predicts each read, and per-instance monitors check the outputs.
module tb_bram_sdp;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic [7:0]  write_address = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_byte_enable = '0;
  logic        read_enable = 1'b0;
  logic [7:0]  read_address = '0;

  logic [31:0] rd_a, rd_b;
  logic        rv_a, rv_b, rc_a, rc_b;

  bram_sdp #(.READ_LATENCY(1), .COLLISION_MODE(0)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .write_byte_enable(write_byte_enable),
    .read_enable(read_enable), .read_address(read_address),
    .read_data(rd_a), .read_valid(rv_a), .read_collision(rc_a)
  );

  bram_sdp #(.READ_LATENCY(2), .COLLISION_MODE(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .write_byte_enable(write_byte_enable),
    .read_enable(read_enable), .read_address(read_address),
    .read_data(rd_b), .read_valid(rv_b), .read_collision(rc_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        coll;
    int          due;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] model [256];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clock) cyc++;

  task automatic check_port(input string nm, input logic v, input logic [31:0] d,
                            input logic c, input bit have, input exp_t e, output bit pop);
    pop = 1'b0;
    total++;
    if (have && e.due == cyc) begin
      pop = 1'b1;
      if (!v) begin
        bad++;
        $display("FAIL %s missing_valid cyc=%0d got valid=0 want valid=1", nm, cyc);
      end else if (d !== e.data || c !== e.coll) begin
        bad++;
        $display("FAIL %s read cyc=%0d got data=%h coll=%b want data=%h coll=%b",
                 nm, cyc, d, c, e.data, e.coll);
      end
    end else if (v || c) begin
      bad++;
      $display("FAIL %s unexpected cyc=%0d got valid=%b coll=%b want 0/0", nm, cyc, v, c);
    end
  endtask

  always @(negedge clock) begin
    bit   h, p;
    exp_t e;
    h = q_a.size() > 0;
    e = h ? q_a[0] : exp_t'{32'h0, 1'b0, -1};
    check_port("lat1_mode0", rv_a, rd_a, rc_a, h, e, p);
    if (p) void'(q_a.pop_front());
    h = q_b.size() > 0;
    e = h ? q_b[0] : exp_t'{32'h0, 1'b0, -1};
    check_port("lat2_mode1", rv_b, rd_b, rc_b, h, e, p);
    if (p) void'(q_b.pop_front());
  end

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // One clock cycle of stimulus; the reference predicts reads from the word as it stood before the edge.
  task automatic drive(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [7:0] ra);
    logic [31:0] old_w, new_w;
    logic        col;
    write_enable      = we;
    write_address     = wa;
    write_data        = wd;
    write_byte_enable = be;
    read_enable       = re;
    read_address      = ra;
    col = we && re && (wa == ra) && (be != 4'h0);
    if (re && reset_n) begin
      old_w = model[ra];
      new_w = old_w;
      if (col)
        for (int i = 0; i < 4; i++) if (be[i]) new_w[i*8 +: 8] = wd[i*8 +: 8];
      q_a.push_back(exp_t'{old_w, col, cyc + 1});
      q_b.push_back(exp_t'{new_w, col, cyc + 2});
    end
    if (we && reset_n)
      for (int i = 0; i < 4; i++) if (be[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_data_a", rd_a, 32'h0);
    check_val("reset_data_b", rd_b, 32'h0);
    check_val("reset_valid", {30'h0, rv_a, rv_b}, 32'h0);
    reset_n = 1'b1;
    idle(1);

    for (int i = 0; i < 256; i++) drive(1'b1, i[7:0], 32'h0, 4'hF, 1'b0, 8'h0);

    drive(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'h0);
    drive(1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10);
    idle(2);

    drive(1'b1, 8'h05, 32'h11223344, 4'hF, 1'b0, 8'h0);
    drive(1'b1, 8'h05, 32'hAABBCCDD, 4'h5, 1'b0, 8'h0);
    drive(1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h05);
    idle(2);

    drive(1'b1, 8'h07, 32'hCAFEF00D, 4'hF, 1'b1, 8'h07);
    drive(1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h07);
    drive(1'b1, 8'h07, 32'h12345678, 4'hF, 1'b0, 8'h0);
    drive(1'b1, 8'h07, 32'hFFFFFFFF, 4'h8, 1'b1, 8'h07);
    drive(1'b1, 8'h07, 32'h99999999, 4'h0, 1'b1, 8'h07);
    idle(2);

    for (int i = 0; i < 4; i++) drive(1'b1, i[7:0], 32'h0A0B0C00 | i, 4'hF, 1'b0, 8'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, i[7:0]);
    drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'hFF);
    idle(3);

    for (int n = 0; n < 400; n++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)));
    idle(3);

    drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h10);
    reset_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    check_val("midreset_data_a", rd_a, 32'h0);
    check_val("midreset_data_b", rd_b, 32'h0);
    drive(1'b1, 8'h10, 32'h55555555, 4'hF, 1'b1, 8'h10);
    idle(2);
    check_val("inreset_valid", {30'h0, rv_a, rv_b}, 32'h0);
    reset_n = 1'b1;
    idle(1);
    check_val("postreset_data_b", rd_b, 32'h0);
    drive(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h10);
    idle(3);

    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
